// File: rtl/serial_word_feeder_if.sv
// Word-in / bit-out handshake bundle for serial_word_feeder.
// master drives words and shift pacing; slave is the feeder.
interface serial_word_feeder_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] word_in;
   logic             word_valid;
   logic             word_ready;
   logic             shift_en;
   logic             serial_out;
   logic             serial_valid;
   logic             word_start;
   logic             busy;

   modport master (
      output word_in, word_valid, shift_en,
      input  word_ready, serial_out, serial_valid,
      input  word_start, busy
   );

   modport slave (
      input  word_in, word_valid, shift_en,
      output word_ready, serial_out, serial_valid,
      output word_start, busy
   );
endinterface

// File: rtl/serial_word_feeder.sv
// Parallel word to bit-serial feeder with a one-entry hold buffer.
// Optional even-parity trailer bit: define SERIAL_FEEDER_PARITY_EN.
module serial_word_feeder #(
   parameter int WIDTH     = 8,
   parameter int LSB_FIRST = 0
) (
   input logic           clk,
   input logic           reset,
   serial_word_feeder_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_FEEDER_PARITY_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
   } state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] hold;
   logic             hold_valid;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    idx;
   logic             last;
   logic             xfer;
   logic             done;

   assign bus.word_ready = !hold_valid && !reset;
   assign xfer = bus.word_valid && bus.word_ready;
   assign last = (cnt == LAST);
   assign idx  = (LSB_FIRST != 0) ? cnt : (LAST - cnt);

   // done: the final bit of the current word is consumed at this edge
`ifdef SERIAL_FEEDER_PARITY_EN
   assign done = bus.shift_en && (state == PARITY);
`else
   assign done = bus.shift_en && (state == SHIFT) && last;
`endif

   // FSM: load, shift, hold capture and back-to-back reload
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         shreg      <= '0;
         hold       <= '0;
         hold_valid <= 1'b0;
         cnt        <= '0;
      end else begin
         if (xfer && (state != IDLE) && !done) begin
            hold       <= bus.word_in;
            hold_valid <= 1'b1;
         end
         if (state == IDLE) begin
            if (xfer) begin
               shreg <= bus.word_in;
               cnt   <= '0;
               state <= SHIFT;
            end
         end else if (done) begin
            cnt <= '0;
            if (hold_valid) begin
               shreg      <= hold;
               hold_valid <= 1'b0;
               state      <= SHIFT;
            end else if (xfer) begin
               shreg <= bus.word_in;
               state <= SHIFT;
            end else begin
               state <= IDLE;
            end
         end else if (bus.shift_en && (state == SHIFT)) begin
`ifdef SERIAL_FEEDER_PARITY_EN
            if (last) state <= PARITY;
            else      cnt   <= cnt + CW'(1);
`else
            cnt <= cnt + CW'(1);
`endif
         end
      end
   end

   // Output decode from registered state only
   always_comb begin
      bus.serial_out = 1'b0;
      if (state == SHIFT) bus.serial_out = shreg[idx];
`ifdef SERIAL_FEEDER_PARITY_EN
      if (state == PARITY) bus.serial_out = ^shreg;
`endif
   end

   assign bus.serial_valid = (state != IDLE);
   assign bus.word_start   = (state == SHIFT) && (cnt == '0);
   assign bus.busy         = (state != IDLE) || hold_valid;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed self-checking bench for serial_word_feeder.
// Parity build adds one trailer bit per word.
module tb_serial_word_feeder;

`ifdef SERIAL_FEEDER_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   serial_word_feeder_if #(.WIDTH(8)) bm ();
   serial_word_feeder_if #(.WIDTH(8)) bl ();

   serial_word_feeder #(.WIDTH(8), .LSB_FIRST(0)) dut_msb (
      .clk   (clk),
      .reset (reset),
      .bus   (bm)
   );

   serial_word_feeder #(.WIDTH(8), .LSB_FIRST(1)) dut_lsb (
      .clk   (clk),
      .reset (reset),
      .bus   (bl)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic eb(input logic [7:0] w, input int i,
                               input bit lsb);
      if (i >= 8) return ^w;
      return lsb ? w[i] : w[7-i];
   endfunction

   task automatic chk_bit(input string tag, input logic [7:0] w,
                          input int i);
      chk({tag, "_out"}, 32'(bm.serial_out), 32'(eb(w, i, 1'b0)));
      chk({tag, "_val"}, 32'(bm.serial_valid), 32'd1);
      chk({tag, "_start"}, 32'(bm.word_start), 32'(i == 0));
   endtask

   task automatic single(input string tag, input logic [7:0] w);
      bm.word_in    = w;
      bm.word_valid = 1'b1;
      tick();
      bm.word_valid = 1'b0;
      for (int i = 0; i < NB; i++) begin
         chk_bit(tag, w, i);
         tick();
      end
      chk({tag, "_end_val"}, 32'(bm.serial_valid), 32'd0);
      chk({tag, "_end_busy"}, 32'(bm.busy), 32'd0);
   endtask

   task automatic b2b(input string tag, input logic [7:0] w1,
                      input logic [7:0] w2);
      bm.word_in    = w1;
      bm.word_valid = 1'b1;
      tick();
      bm.word_in = w2;
      for (int i = 0; i < NB; i++) begin
         chk_bit({tag, "_a"}, w1, i);
         chk({tag, "_a_rdy"}, 32'(bm.word_ready), 32'(i == 0));
         tick();
         bm.word_valid = 1'b0;
      end
      for (int i = 0; i < NB; i++) begin
         chk_bit({tag, "_b"}, w2, i);
         chk({tag, "_b_rdy"}, 32'(bm.word_ready), 32'd1);
         tick();
      end
      chk({tag, "_end_val"}, 32'(bm.serial_valid), 32'd0);
      chk({tag, "_end_busy"}, 32'(bm.busy), 32'd0);
   endtask

   initial begin
      bm.word_in    = '0;
      bm.word_valid = 1'b0;
      bm.shift_en   = 1'b1;
      bl.word_in    = '0;
      bl.word_valid = 1'b0;
      bl.shift_en   = 1'b1;
      #1 reset = 1'b1;
      tick();
      tick();
      chk("rst_out", 32'(bm.serial_out), 32'd0);
      chk("rst_val", 32'(bm.serial_valid), 32'd0);
      chk("rst_start", 32'(bm.word_start), 32'd0);
      chk("rst_busy", 32'(bm.busy), 32'd0);
      chk("rst_rdy", 32'(bm.word_ready), 32'd0);
      reset = 1'b0;
      tick();
      chk("idle_rdy", 32'(bm.word_ready), 32'd1);

      single("t1_e0", 8'hE0);

      b2b("t2", 8'hA5, 8'h3C);

      bm.word_in    = 8'hF0;
      bm.word_valid = 1'b1;
      tick();
      bm.word_valid = 1'b0;
      for (int i = 0; i < NB; i++) begin
         chk_bit("t3_p0", 8'hF0, i);
         bm.shift_en = 1'b0;
         tick();
         chk_bit("t3_p1", 8'hF0, i);
         bm.shift_en = 1'b1;
         tick();
      end
      chk("t3_end_val", 32'(bm.serial_valid), 32'd0);

      bl.word_in    = 8'h01;
      bl.word_valid = 1'b1;
      tick();
      bl.word_valid = 1'b0;
      for (int i = 0; i < NB; i++) begin
         chk("t4_out", 32'(bl.serial_out), 32'(eb(8'h01, i, 1'b1)));
         chk("t4_val", 32'(bl.serial_valid), 32'd1);
         tick();
      end
      chk("t4_end_val", 32'(bl.serial_valid), 32'd0);

      bm.word_in    = 8'hFF;
      bm.word_valid = 1'b1;
      tick();
      bm.word_in = 8'h55;
      chk("t5_b0", 32'(bm.serial_out), 32'd1);
      tick();
      bm.word_valid = 1'b0;
      chk("t5_b1", 32'(bm.serial_out), 32'd1);
      chk("t5_held", 32'(bm.word_ready), 32'd0);
      tick();
      chk("t5_b2", 32'(bm.serial_out), 32'd1);
      reset = 1'b1;
      #2;
      chk("t5_rst_out", 32'(bm.serial_out), 32'd0);
      chk("t5_rst_val", 32'(bm.serial_valid), 32'd0);
      chk("t5_rst_busy", 32'(bm.busy), 32'd0);
      chk("t5_rst_rdy", 32'(bm.word_ready), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      chk("t5_post_busy", 32'(bm.busy), 32'd0);
      chk("t5_post_val", 32'(bm.serial_valid), 32'd0);
      chk("t5_post_rdy", 32'(bm.word_ready), 32'd1);
      single("t5_81", 8'h81);

      b2b("t6", 8'h07, 8'h03);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Upstream stage for the bit-serial sequence detector: takes parallel words over a valid/ready handshake and emits them one bit per enabled clock on a serial line that drives the detector's data_in.
- A one-entry holding buffer lets back-to-back words stream with no idle bit between them.
- Pacing comes from a downstream shift enable.

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.
- LSB_FIRST, 0, 0 = MSB shifted first; 1 = LSB shifted first.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- word_in  input  WIDTH  parallel word to serialize
- word_valid  input  1  word_in valid
- word_ready  output  1  feeder can accept word_in this cycle
- shift_en  input  1  downstream consumes current bit at this clock edge
- serial_out  output  1  current serial bit (to detector data_in)
- serial_valid  output  1  serial_out carries a real data bit
- word_start  output  1  serial_out is the first bit of a word
- busy  output  1  shifter or holding buffer occupied

Behaviour:
- Reset values (asynchronous): state IDLE, serial_out 0, serial_valid 0, word_start 0, busy 0, holding buffer empty. word_ready is forced 0 while reset is high.
- Internal storage: shift register (WIDTH), bit counter ($clog2(WIDTH) bits, 0..WIDTH-1), holding register plus hold_valid flag.
- Handshake:
  - word_ready = !hold_valid (and !reset).
  - A word transfers at an edge where word_valid && word_ready.
  - word_in must be held stable while word_valid is high and word_ready is low.
- State IDLE:
  - serial_valid = 0, serial_out = 0.
  - On transfer, load the shift register and go to SHIFT. The first bit is on serial_out in the cycle after the transfer edge (latency 1).
- State SHIFT:
  - serial_valid = 1.
  - serial_out = current bit: word[WIDTH-1-cnt] for MSB-first, word[cnt] for LSB-first.
  - word_start = (cnt == 0).
  - Edge with shift_en = 1 advances cnt. With shift_en = 0, all outputs and cnt hold.
- Last bit (cnt == WIDTH-1) consumed with shift_en = 1:
  - If hold_valid: move the holding register into the shifter, cnt = 0, clear hold_valid. No gap.
  - Else, if a transfer occurs at the same edge: load word_in directly into the shifter. No gap.
  - Otherwise go to IDLE.
- Transfer while SHIFT and the shifter is not finishing this edge: the word goes into the holding register and hold_valid is set. word_ready is then 0 until the hold register drains.
- Simultaneous hold drain and new transfer: not possible, because word_ready = 0 while hold_valid.
- busy = (state != IDLE) || hold_valid.
- Reset mid-word: all in-flight and held words are discarded immediately. No partial word resumes after reset release.

Optional Feature:
- Macro: SERIAL_FEEDER_PARITY_EN.
- Defined:
  - After the last data bit of each word, state PARITY emits one extra bit: even parity (XOR of all WIDTH data bits).
  - In PARITY: serial_valid = 1, word_start = 0, and the bit is consumed on shift_en like a data bit.
  - Next-word loading (hold or direct transfer) happens at the edge that consumes the parity bit.
  - Word period is WIDTH+1 enabled cycles.
- Not defined: no PARITY state; word period is exactly WIDTH enabled cycles.

Test Plan:
1. Single word, MSB-first:
   - Stimulus: after reset, transfer 8'hE0 with shift_en = 1.
   - Response: serial_out = 1,1,1,0,0,0,0,0 on cycles 1-8 after the transfer edge; word_start only on cycle 1; serial_valid low on cycle 9; busy low on cycle 9.
2. Back-to-back words:
   - Stimulus: word_valid held with 8'hA5, then 8'h3C.
   - Response: 16 contiguous valid bits 10100101 00111100; word_ready low from the edge after the second transfer until the edge loading 8'h3C.
3. Paced shifting:
   - Stimulus: 8'hF0 with shift_en toggling 1,0,1,0...
   - Response: each bit held 2 cycles; the sequence is unchanged.
4. LSB-first:
   - Stimulus: LSB_FIRST = 1, word 8'h01.
   - Response: serial_out = 1 then seven 0s.
5. Reset mid-word:
   - Stimulus: 8'hFF with a second word held; assert reset after 3 bits.
   - Response: serial_out/serial_valid/busy go 0 immediately. After release, a new transfer of 8'h81 yields exactly 1,0,0,0,0,0,0,1 with no residue.
6. Parity (macro defined):
   - Stimulus: 8'h07, then 8'h03 back-to-back.
   - Response: 9th bit 1, 18th bit 0; no gap between words.
